// File: rtl/psc_pkg.sv
// Shared types and constants for the pattern scan controller.
package psc_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Map a raw length request onto the supported range 1..MAX_LEN.
    function automatic logic [3:0] eff_len(input logic [3:0] len);
        logic [3:0] res;
        res = len;
        if (len == 4'd0) begin
            res = 4'd1;
        end else if (len > 4'(MAX_LEN)) begin
            res = 4'(MAX_LEN);
        end
        return res;
    endfunction

    // Low-order mask covering the newest len history bits.
    function automatic logic [BYTE_W-1:0] len_mask(input logic [3:0] len);
        logic [BYTE_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < 32'(len)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Bit history, per-frame bit counter and pattern comparator.
module pattern_match_core
    import psc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    input  logic [BYTE_W-1:0] pattern,
    input  logic [3:0]        len,
    output logic              hit
);

    logic [BYTE_W-1:0] history;
    logic [3:0]        seen;
    logic [BYTE_W-1:0] window;

    // Compare the history including the current bit against the pattern.
    always_comb begin
        window = {history[BYTE_W-2:0], bit_in};
        hit    = shift_en
                 && (seen >= (len - 4'd1))
                 && (((window ^ pattern) & len_mask(len)) == '0);
    end

    // Shift history and count frame bits, saturating at the longest pattern.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            history <= '0;
            seen    <= '0;
        end else if (shift_en) begin
            history <= window;
            if (seen != 4'(MAX_LEN)) begin
                seen <= seen + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Byte-serialising pattern scanner with per-frame match counting.
// Optional feature: define PSC_SATURATE_EN to make match_count saturate
// at all-ones instead of wrapping.
module pattern_scan_ctrl
    import psc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [BYTE_W-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              frame_last,
    output logic              byte_ready,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] shreg;
    logic [2:0]        bit_idx;
    logic              last_q;
    logic              busy_q;
    logic [BYTE_W-1:0] pattern_q;
    logic [3:0]        len_q;
    logic              accept;
    logic              first_byte;
    logic              shift_en;
    logic              hit;

    assign busy        = busy_q;
    assign accept      = byte_valid && byte_ready;
    assign first_byte  = accept && !busy_q;
    assign shift_en    = (state_q == SHIFT);

    pattern_match_core u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (first_byte),
        .shift_en (shift_en),
        .bit_in   (shreg[BYTE_W-1]),
        .pattern  (pattern_q),
        .len      (len_q),
        .hit      (hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus state-decoded handshake and done outputs.
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_idx == 3'd7) begin
                    state_d = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte capture, MSB-first serialisation, frame tracking and config latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_idx   <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            pattern_q <= '0;
            len_q     <= 4'd1;
        end else begin
            if (accept) begin
                shreg   <= byte_in;
                bit_idx <= '0;
                last_q  <= frame_last;
                busy_q  <= 1'b1;
            end else if (shift_en) begin
                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                bit_idx <= bit_idx + 3'd1;
            end else if (state_q == DONE) begin
                busy_q  <= 1'b0;
            end
            if (cfg_we && !busy_q) begin
                pattern_q <= cfg_pattern;
                len_q     <= eff_len(cfg_len);
            end
        end
    end

    // Registered match pulse and per-frame match counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_pulse <= 1'b0;
            match_count <= '0;
        end else begin
            match_pulse <= hit;
            if (first_byte) begin
                match_count <= '0;
            end else if (hit) begin
`ifdef PSC_SATURATE_EN
                if (match_count != '1) begin
                    match_count <= match_count + 1'b1;
                end
`else
                match_count <= match_count + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl.
module tb_pattern_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        frame_last;

    logic        byte_ready, match_pulse, busy, done;
    logic [15:0] match_count;
    logic        s_byte_ready, s_match_pulse, s_busy, s_done;
    logic [1:0]  s_match_count;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    int unsigned cyc          = 0;
    int unsigned pulse_total  = 0;
    int unsigned done_total   = 0;

    pattern_scan_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_last  (frame_last),
        .byte_ready  (byte_ready),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    pattern_scan_ctrl #(.CNT_W(2)) u_small (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_last  (frame_last),
        .byte_ready  (s_byte_ready),
        .match_pulse (s_match_pulse),
        .match_count (s_match_count),
        .busy        (s_busy),
        .done        (s_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (match_pulse) pulse_total <= pulse_total + 1;
        if (done)        done_total  <= done_total + 1;
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int unsigned n;
        n = 0;
        while (!byte_ready && n < 40) begin
            tick(1);
            n++;
        end
        if (!byte_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_ready: byte_ready=%0b after %0d cycles, required 1", byte_ready, n);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic lst, output int unsigned acc_cyc);
        wait_ready();
        byte_in    = b;
        frame_last = lst;
        byte_valid = 1'b1;
        tick(1);
        acc_cyc    = cyc;
        byte_valid = 1'b0;
        frame_last = 1'b0;
    endtask

    task automatic wait_frame_end();
        int unsigned n;
        n = 0;
        while ((busy || !byte_ready) && n < 40) begin
            tick(1);
            n++;
        end
        if (busy || !byte_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL frame_end: busy=%0b byte_ready=%0b after %0d cycles, required 0/1", busy, byte_ready, n);
        end
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_we      = 1'b1;
        tick(1);
        cfg_we      = 1'b0;
    endtask

    // Single-byte frame; reports match pulses and done pulses it produced.
    task automatic run_frame1(input logic [7:0] b, output int unsigned np, output int unsigned nd);
        int unsigned p0, d0, a;
        p0 = pulse_total;
        d0 = done_total;
        send_byte(b, 1'b1, a);
        wait_frame_end();
        np = pulse_total - p0;
        nd = done_total - d0;
    endtask

    task automatic check_frame(input string name, input int unsigned np, input int unsigned nd,
                               input int unsigned exp_n);
        tests_run++;
        if (np !== exp_n) begin
            tests_failed++;
            $display("FAIL %s_pulses: got %0d, required %0d", name, np, exp_n);
        end
        tests_run++;
        if (match_count !== 16'(exp_n)) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d, required %0d", name, match_count, exp_n);
        end
        tests_run++;
        if (nd !== 1) begin
            tests_failed++;
            $display("FAIL %s_done: got %0d done pulses, required 1", name, nd);
        end
    endtask

    task automatic test_reset();
        int unsigned np, nd;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tests_run++;
        if ({byte_ready, busy, done, match_pulse} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_flags: ready/busy/done/pulse=%b, required 1000",
                     {byte_ready, busy, done, match_pulse});
        end
        tests_run++;
        if (match_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d, required 0", match_count);
        end
        // default pattern 0, length 1: every zero bit matches
        run_frame1(8'hF0, np, nd);
        check_frame("reset_default_cfg", np, nd, 4);
    endtask

    task automatic test_basic();
        int unsigned p0, d0, a;
        configure(8'b011, 4'd3);
        p0 = pulse_total;
        d0 = done_total;
        send_byte(8'h36, 1'b1, a);
        tick(2);
        tests_run++;
        if ({busy, byte_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL basic_in_shift: busy/ready=%b, required 10", {busy, byte_ready});
        end
        wait_frame_end();
        check_frame("basic", pulse_total - p0, done_total - d0, 2);
        tick(5);
        tests_run++;
        if (match_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL basic_hold: got %0d, required 2", match_count);
        end
    endtask

    task automatic test_byte_boundary();
        int unsigned p0, d0, a0, a1;
        p0 = pulse_total;
        d0 = done_total;
        send_byte(8'h01, 1'b0, a0);
        wait_ready();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL boundary_busy_between: got %0b, required 1", busy);
        end
        send_byte(8'h80, 1'b1, a1);
        tests_run++;
        if (a1 - a0 !== 9) begin
            tests_failed++;
            $display("FAIL boundary_spacing: got %0d cycles, required 9", a1 - a0);
        end
        wait_frame_end();
        check_frame("boundary", pulse_total - p0, done_total - d0, 1);
    endtask

    task automatic test_no_carry();
        int unsigned np, nd;
        run_frame1(8'h01, np, nd);
        run_frame1(8'h80, np, nd);
        check_frame("no_carry", np, nd, 0);
    endtask

    task automatic test_overlap();
        int unsigned np, nd;
        configure(8'b11, 4'd2);
        run_frame1(8'hFF, np, nd);
        check_frame("overlap", np, nd, 7);
    endtask

    task automatic test_len_clamp();
        int unsigned np, nd;
        configure(8'h01, 4'd0);
        run_frame1(8'hA5, np, nd);
        check_frame("len0", np, nd, 4);
        configure(8'hA5, 4'd15);
        run_frame1(8'hA5, np, nd);
        check_frame("len15", np, nd, 1);
    endtask

    task automatic test_cfg_busy();
        int unsigned p0, d0, a, np, nd;
        configure(8'b011, 4'd3);
        p0 = pulse_total;
        d0 = done_total;
        send_byte(8'h36, 1'b1, a);
        tick(2);
        cfg_pattern = 8'b00;
        cfg_len     = 4'd2;
        cfg_we      = 1'b1;
        tick(1);
        cfg_we      = 1'b0;
        wait_frame_end();
        check_frame("cfg_busy_cur", pulse_total - p0, done_total - d0, 2);
        run_frame1(8'h36, np, nd);
        check_frame("cfg_busy_next", np, nd, 2);
        configure(8'b00, 4'd2);
        run_frame1(8'h36, np, nd);
        check_frame("cfg_idle_new", np, nd, 1);
    endtask

    task automatic test_back_to_back();
        int unsigned p0, d0, a0, a1;
        configure(8'b011, 4'd3);
        p0 = pulse_total;
        d0 = done_total;
        send_byte(8'h36, 1'b1, a0);
        tick(2);
        // stray byte while shifting must not be consumed
        byte_in    = 8'hFF;
        byte_valid = 1'b1;
        tick(3);
        byte_valid = 1'b0;
        send_byte(8'h36, 1'b1, a1);
        tests_run++;
        if (a1 - a0 !== 10) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d cycles, required 10", a1 - a0);
        end
        wait_frame_end();
        tests_run++;
        if (pulse_total - p0 !== 4) begin
            tests_failed++;
            $display("FAIL b2b_pulses: got %0d, required 4", pulse_total - p0);
        end
        tests_run++;
        if (done_total - d0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_dones: got %0d, required 2", done_total - d0);
        end
        tests_run++;
        if (match_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d, required 2", match_count);
        end
    endtask

    task automatic test_saturate();
        int unsigned np, nd;
        logic [1:0] exp_small;
`ifdef PSC_SATURATE_EN
        exp_small = 2'd3;
`else
        exp_small = 2'd1;
`endif
        configure(8'b11, 4'd2);
        run_frame1(8'hFC, np, nd);
        check_frame("sat_wide", np, nd, 5);
        tests_run++;
        if (s_match_count !== exp_small) begin
            tests_failed++;
            $display("FAIL sat_small_count: got %0d, required %0d", s_match_count, exp_small);
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned d0, a;
        configure(8'b011, 4'd3);
        d0 = done_total;
        send_byte(8'h36, 1'b0, a);
        send_byte(8'h36, 1'b1, a);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tests_run++;
        if ({byte_ready, busy, match_pulse} !== 3'b100) begin
            tests_failed++;
            $display("FAIL midreset_flags: ready/busy/pulse=%b, required 100",
                     {byte_ready, busy, match_pulse});
        end
        tests_run++;
        if (match_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d, required 0", match_count);
        end
        tick(12);
        tests_run++;
        if (done_total - d0 !== 0) begin
            tests_failed++;
            $display("FAIL midreset_done: got %0d done pulses, required 0", done_total - d0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        byte_in     = '0;
        byte_valid  = 1'b0;
        frame_last  = 1'b0;
        tick(1);
        test_reset();
        test_basic();
        test_byte_boundary();
        test_no_carry();
        test_overlap();
        test_len_clamp();
        test_cfg_busy();
        test_back_to_back();
        test_saturate();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
